opram_loader: RTL and testbench
===============================

Name: opram_loader

Overview:
- Serial program loader that writes program bytes into opram_control.
- Receives 8N1 UART frames from a host, checks a length and checksum framing, and issues one-cycle write strobes with an incrementing address.
- Holds the CPU in reset while loading and releases it only after a good image.
- Sits beside opram_control in top and drives its write/writeop/writeaddr/write_rst inputs, which are currently tied off.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, computed with integer division.
- TIMEOUT_BITS, 64, idle bit-times allowed between bytes of a frame before abort.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- rxd  input  1  UART receive line; idles high; asynchronous to clk.
- load_en  input  1  level; 1 = loader armed, 0 = loader idle and CPU free to run.
- write  output  1  one-cycle write strobe to opram_control.
- writeop  output  8  data byte for opram.
- writeaddr  output  8  opram address.
- write_rst  output  1  active-low opram clear; pulses 0 for one cycle.
- cpu_rst  output  1  active-low CPU reset; 0 while loading or after an error.
- busy  output  1  1 in any state other than IDLE, DONE or ERR.
- done  output  1  1 in DONE.
- err  output  1  1 in ERR.

Behaviour:
- Reset values: write=0, writeop=0, writeaddr=0, write_rst=1, cpu_rst=1, busy=0, done=0, err=0. State goes to IDLE.
- Input sync: rxd passes through a two-flop synchroniser before any use.
- Start detection: a start bit is a falling edge on the synchronised rxd.
  - The line is resampled at CLKS_PER_BIT/2; if it is high there, the start is false and the receiver returns to idle.
- Data and stop bits: sampled at mid-bit, LSB first.
- Stop bit = 0 gives a frame error, and the loader goes to ERR.
- Host frame format: LEN, then N data bytes, then SUM.
  - LEN = 0 means N = 256.
  - SUM is the 8-bit modulo sum of the data bytes.
- States:
  - IDLE:
    - cpu_rst=1.
    - On load_en=1, go to CLR.
  - CLR:
    - write_rst=0 for exactly one cycle; cpu_rst=0.
    - Then go to LEN.
  - LEN:
    - On a byte, store count = (byte==0) ? 256 : byte.
    - Set writeaddr=0 and clear the running sum.
    - Then go to DATA.
  - DATA:
    - Each received byte sets writeop=byte.
    - write=1 for one cycle, on the cycle after the stop-bit sample.
    - writeaddr is held stable during the strobe and incremented the cycle after it.
    - After the Nth byte, go to SUM.
    - With N = 256, writeaddr wraps to 0 after address 255; no write beyond N occurs.
  - SUM:
    - Received byte equal to the running sum: go to DONE.
    - Otherwise go to ERR.
  - DONE:
    - done=1 and cpu_rst=1.
    - Stays until load_en=0, then goes to IDLE.
  - ERR:
    - err=1 and cpu_rst=0; the CPU stays held.
    - Stays until load_en=0, then goes to IDLE.
- Errors and aborts:
  - load_en=0 in CLR, LEN, DATA or SUM aborts to IDLE with cpu_rst=1.
    - Partially written opram contents are not restored.
  - No byte received within TIMEOUT_BITS*CLKS_PER_BIT cycles in LEN, DATA or SUM sends the loader to ERR.
    - The timer is cleared at every start bit.
- Write timing: write is never asserted on two consecutive cycles; minimum spacing is one UART frame.
- rst asserted mid-load:
  - All outputs return immediately to their reset values.
  - Any write strobe in progress is cut off.
- Bytes arriving in IDLE, DONE or ERR are received and discarded.

Decomposition:
- Include file gcore_loader_defs.vh holds:
  - state encodings (IDLE, CLR, LEN, DATA, SUM, DONE, ERR, 3 bits);
  - the CLKS_PER_BIT and timeout-count derivation macros.
- Sub-module uart_rx_byte:
  - ports: clk, rst, rxd, data[7:0], valid (one-cycle pulse), frame_err (one-cycle pulse);
  - contains the synchroniser, bit counter and baud counter.
- opram_loader holds the framing FSM, byte counter, address counter, checksum and timeout counter.

Test Plan:
- Basic load: load_en=1, send LEN=3, data 0x12 0x34 0x56, SUM=0x9C -> write_rst low one cycle; three write pulses at addresses 0,1,2 with those bytes; done=1; cpu_rst=1.
- Bad checksum: LEN=2, data 0x01 0x02, SUM=0x04 -> two writes, then err=1 with cpu_rst=0. Dropping load_en -> IDLE, err=0, cpu_rst=1.
- Full image: LEN=0x00, 256 bytes with value = address, SUM=0x80 -> 256 writes covering addresses 0..255, addresses wrap without a 257th write, done=1.
- Frame error: second data byte sent with stop bit 0 -> err=1; no write for that byte.
- Glitch and timeout: a 1-cycle low glitch on rxd in LEN produces no byte. After LEN=4, one data byte, then silence for 64 bit-times -> err=1.
- Reset mid-load: drop rst during DATA after 2 of 5 bytes -> all outputs at reset values asynchronously. After release with load_en=1, a fresh load of LEN=1, 0xAA, SUM=0xAA gives done=1.

Source files
------------

// File: rtl/opram_loader_pkg.sv
// Shared types and derived timing constants for the opram serial program loader.
package opram_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CLR  = 3'd1,
      ST_LEN  = 3'd2,
      ST_DATA = 3'd3,
      ST_SUM  = 3'd4,
      ST_DONE = 3'd5,
      ST_ERR  = 3'd6
   } ld_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   function automatic int timeout_cycles(input int clk_hz, input int baud, input int bits);
      return bits * clks_per_bit(clk_hz, baud);
   endfunction

endpackage

// File: rtl/opram_loader_if.sv
// Write port bundle from the loader into opram_control.
interface opram_loader_if;
   logic       write;
   logic [7:0] writeop;
   logic [7:0] writeaddr;
   logic       write_rst;

   modport master (output write, writeop, writeaddr, write_rst);
   modport slave  (input  write, writeop, writeaddr, write_rst);
endinterface

// File: rtl/opram_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchroniser, false-start rejection, mid-bit sampling.
module uart_rx_byte
   import opram_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       start
);

   localparam int            CW      = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

   rx_state_e     state_q, state_d;
   logic          sync1_q, sync2_q, sync3_q;
   logic [CW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          fall;

   assign fall = sync3_q & ~sync2_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RX_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         sync3_q <= 1'b1;
         baud_q  <= '0;
         bit_q   <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync1_q <= rxd;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (fall) begin
               state_d = RX_START;
               baud_d  = '0;
            end
         end
         RX_START: begin
            // A line back high at half a bit was a glitch, not a start bit
            if (baud_q == HALF_M1) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = sync2_q ? RX_IDLE : RX_DATA;
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         RX_DATA: begin
            if (baud_q == LAST) begin
               baud_d  = '0;
               shift_d = {sync2_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = RX_STOP;
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         RX_STOP: begin
            if (baud_q == LAST) begin
               baud_d  = '0;
               state_d = RX_IDLE;
               valid_d = sync2_q;
               ferr_d  = ~sync2_q;
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_comb begin
      data      = shift_q;
      valid     = valid_q;
      frame_err = ferr_q;
      start     = (state_q == RX_IDLE) && fall;
   end

endmodule

// File: rtl/opram_loader.sv
// Serial program loader: LEN / data / SUM framing over UART, writes opram and gates CPU reset.
module opram_loader
   import opram_loader_pkg::*;
#(
   parameter int CLK_HZ       = 50000000,
   parameter int BAUD         = 115200,
   parameter int TIMEOUT_BITS = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic rxd,
   input  logic load_en,
   opram_loader_if.master bus,
   output logic cpu_rst,
   output logic busy,
   output logic done,
   output logic err
);

   localparam int            CPB     = clks_per_bit(CLK_HZ, BAUD);
   localparam int            TO_CYC  = timeout_cycles(CLK_HZ, BAUD, TIMEOUT_BITS);
   localparam int            TW      = $clog2(TO_CYC + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

   ld_state_e     state_q, state_d;
   logic [8:0]    count_q, count_d;
   logic [7:0]    addr_q, addr_d;
   logic [7:0]    sum_q, sum_d;
   logic [7:0]    wop_q, wop_d;
   logic          wr_q, wr_d;
   logic [TW-1:0] timer_q, timer_d;

   logic [7:0]    rx_data;
   logic          rx_valid, rx_ferr, rx_start;
   logic          loading, timeout;

   uart_rx_byte #(.CLKS_PER_BIT(CPB)) u_rx (
      .clk       (clk),
      .rst       (rst),
      .rxd       (rxd),
      .data      (rx_data),
      .valid     (rx_valid),
      .frame_err (rx_ferr),
      .start     (rx_start)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
         addr_q  <= '0;
         sum_q   <= '0;
         wop_q   <= '0;
         wr_q    <= 1'b0;
         timer_q <= '0;
      end else begin
         count_q <= count_d;
         addr_q  <= addr_d;
         sum_q   <= sum_d;
         wop_q   <= wop_d;
         wr_q    <= wr_d;
         timer_q <= timer_d;
      end
   end

   assign loading = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_SUM);
   assign timeout = (timer_q == TO_LAST);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      sum_d   = sum_q;
      wop_d   = wop_q;
      wr_d    = 1'b0;
      // Address advances the cycle after each strobe so it is stable during it
      addr_d  = wr_q ? addr_q + 8'd1 : addr_q;
      timer_d = '0;
      if (loading) timer_d = rx_start ? '0 : timer_q + TW'(1);

      case (state_q)
         ST_IDLE: begin
            if (load_en) state_d = ST_CLR;
         end
         ST_CLR: begin
            state_d = load_en ? ST_LEN : ST_IDLE;
         end
         ST_LEN: begin
            if (!load_en) begin
               state_d = ST_IDLE;
            end else if (rx_ferr) begin
               state_d = ST_ERR;
            end else if (rx_valid) begin
               count_d = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
               addr_d  = '0;
               sum_d   = '0;
               state_d = ST_DATA;
            end else if (timeout) begin
               state_d = ST_ERR;
            end
         end
         ST_DATA: begin
            if (!load_en) begin
               state_d = ST_IDLE;
            end else if (rx_ferr) begin
               state_d = ST_ERR;
            end else if (rx_valid) begin
               wop_d   = rx_data;
               wr_d    = 1'b1;
               sum_d   = sum_q + rx_data;
               count_d = count_q - 9'd1;
               if (count_q == 9'd1) state_d = ST_SUM;
            end else if (timeout) begin
               state_d = ST_ERR;
            end
         end
         ST_SUM: begin
            if (!load_en) begin
               state_d = ST_IDLE;
            end else if (rx_ferr) begin
               state_d = ST_ERR;
            end else if (rx_valid) begin
               state_d = (rx_data == sum_q) ? ST_DONE : ST_ERR;
            end else if (timeout) begin
               state_d = ST_ERR;
            end
         end
         ST_DONE, ST_ERR: begin
            if (!load_en) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.write     = wr_q;
      bus.writeop   = wop_q;
      bus.writeaddr = addr_q;
      bus.write_rst = (state_q != ST_CLR);
      cpu_rst       = (state_q == ST_IDLE) || (state_q == ST_DONE);
      busy          = (state_q == ST_CLR) || loading;
      done          = (state_q == ST_DONE);
      err           = (state_q == ST_ERR);
   end

endmodule

// File: tb/tb_opram_loader.sv
// Scoreboard bench for opram_loader: expected writes are queued as bytes are sent.
module tb_opram_loader;

   localparam int CLK_HZ  = 1000000;
   localparam int BAUD    = 125000;
   localparam int TO_BITS = 64;
   localparam int CPB     = CLK_HZ / BAUD;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rxd = 1'b1;
   logic load_en = 1'b0;
   logic cpu_rst, busy, done, err;

   int  checks = 0;
   int  errors = 0;
   int  n_writes = 0;
   int  n_wrst_lo = 0;
   logic prev_wr = 1'b0;
   wr_t exp_q[$];

   opram_loader_if bus_if ();

   opram_loader #(
      .CLK_HZ       (CLK_HZ),
      .BAUD         (BAUD),
      .TIMEOUT_BITS (TO_BITS)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .rxd     (rxd),
      .load_en (load_en),
      .bus     (bus_if),
      .cpu_rst (cpu_rst),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   always #5 clk = ~clk;

   initial begin
      #(900000);
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // Write monitor / scoreboard
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (bus_if.write === 1'b1) begin
            n_writes++;
            checks++;
            if (prev_wr === 1'b1) begin
               errors++;
               $display("FAIL write_spacing: write high on two consecutive cycles at addr %h", bus_if.writeaddr);
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: got addr %h data %h, required no write", bus_if.writeaddr, bus_if.writeop);
            end else begin
               e = exp_q.pop_front();
               if ({bus_if.writeaddr, bus_if.writeop} !== e) begin
                  errors++;
                  $display("FAIL write_data: got addr %h data %h, required addr %h data %h",
                           bus_if.writeaddr, bus_if.writeop, e.addr, e.data);
               end
            end
         end
         if (bus_if.write_rst === 1'b0) n_wrst_lo++;
         prev_wr = bus_if.write;
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(negedge clk);
      end
      rxd = stop;
      repeat (CPB) @(negedge clk);
      rxd = 1'b1;
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      logic [22:0] obs;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      obs = {bus_if.write, bus_if.writeop, bus_if.writeaddr, bus_if.write_rst, cpu_rst, busy, done, err};
      checks++;
      if (obs !== {1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 3'b000}) begin
         errors++;
         $display("FAIL reset_outputs: got %h required %h", obs, {1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 3'b000});
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      int w0, l0;
      w0 = n_writes;
      l0 = n_wrst_lo;
      load_en = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if ({busy, cpu_rst} !== 2'b10) begin
         errors++;
         $display("FAIL basic_loading: got busy,cpu_rst %b required 10", {busy, cpu_rst});
      end
      send_byte(8'd3, 1'b1);
      push(8'd0, 8'h12); send_byte(8'h12, 1'b1);
      push(8'd1, 8'h34); send_byte(8'h34, 1'b1);
      push(8'd2, 8'h56); send_byte(8'h56, 1'b1);
      send_byte(8'h9C, 1'b1);
      repeat (2 * CPB) @(negedge clk);
      checks++;
      if ({done, err, cpu_rst, busy} !== 4'b1010) begin
         errors++;
         $display("FAIL basic_done: got done,err,cpu_rst,busy %b required 1010", {done, err, cpu_rst, busy});
      end
      checks++;
      if (n_writes - w0 !== 3) begin
         errors++;
         $display("FAIL basic_write_count: got %0d required 3", n_writes - w0);
      end
      checks++;
      if (n_wrst_lo - l0 !== 1) begin
         errors++;
         $display("FAIL basic_write_rst_cycles: got %0d required 1", n_wrst_lo - l0);
      end
      load_en = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({done, busy, cpu_rst} !== 3'b001) begin
         errors++;
         $display("FAIL basic_release: got done,busy,cpu_rst %b required 001", {done, busy, cpu_rst});
      end
   endtask

   task automatic test_bad_sum();
      int w0;
      w0 = n_writes;
      load_en = 1'b1;
      repeat (4) @(negedge clk);
      send_byte(8'd2, 1'b1);
      push(8'd0, 8'h01); send_byte(8'h01, 1'b1);
      push(8'd1, 8'h02); send_byte(8'h02, 1'b1);
      send_byte(8'h04, 1'b1);
      repeat (2 * CPB) @(negedge clk);
      checks++;
      if ({err, cpu_rst, done} !== 3'b100) begin
         errors++;
         $display("FAIL badsum_err: got err,cpu_rst,done %b required 100", {err, cpu_rst, done});
      end
      checks++;
      if (n_writes - w0 !== 2) begin
         errors++;
         $display("FAIL badsum_write_count: got %0d required 2", n_writes - w0);
      end
      load_en = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({err, cpu_rst, busy} !== 3'b010) begin
         errors++;
         $display("FAIL badsum_release: got err,cpu_rst,busy %b required 010", {err, cpu_rst, busy});
      end
   endtask

   task automatic test_full_image();
      int w0;
      w0 = n_writes;
      load_en = 1'b1;
      repeat (4) @(negedge clk);
      send_byte(8'h00, 1'b1);
      for (int i = 0; i < 256; i++) begin
         push(8'(i), 8'(i));
         send_byte(8'(i), 1'b1);
      end
      send_byte(8'h80, 1'b1);
      repeat (2 * CPB) @(negedge clk);
      checks++;
      if ({done, err} !== 2'b10) begin
         errors++;
         $display("FAIL full_done: got done,err %b required 10", {done, err});
      end
      checks++;
      if (n_writes - w0 !== 256) begin
         errors++;
         $display("FAIL full_write_count: got %0d required 256", n_writes - w0);
      end
      checks++;
      if (bus_if.writeaddr !== 8'h00) begin
         errors++;
         $display("FAIL full_addr_wrap: got %h required 00", bus_if.writeaddr);
      end
      load_en = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_frame_err();
      int w0;
      w0 = n_writes;
      load_en = 1'b1;
      repeat (4) @(negedge clk);
      send_byte(8'd3, 1'b1);
      push(8'd0, 8'h11); send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      checks++;
      if ({err, cpu_rst} !== 2'b10) begin
         errors++;
         $display("FAIL frame_err_flag: got err,cpu_rst %b required 10", {err, cpu_rst});
      end
      checks++;
      if (n_writes - w0 !== 1) begin
         errors++;
         $display("FAIL frame_err_write_count: got %0d required 1", n_writes - w0);
      end
      load_en = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_glitch_timeout();
      int w0;
      w0 = n_writes;
      load_en = 1'b1;
      repeat (4) @(negedge clk);
      rxd = 1'b0;
      @(negedge clk);
      rxd = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      checks++;
      if ({busy, err, done} !== 3'b100 || n_writes !== w0) begin
         errors++;
         $display("FAIL glitch_ignored: got busy,err,done %b writes %0d required 100 writes 0",
                  {busy, err, done}, n_writes - w0);
      end
      send_byte(8'd4, 1'b1);
      push(8'd0, 8'h5A); send_byte(8'h5A, 1'b1);
      repeat (40 * CPB) @(negedge clk);
      checks++;
      if ({busy, err} !== 2'b10) begin
         errors++;
         $display("FAIL timeout_early: got busy,err %b required 10", {busy, err});
      end
      for (int i = 0; i < 40 * CPB && err !== 1'b1; i++) @(negedge clk);
      checks++;
      if ({err, cpu_rst} !== 2'b10) begin
         errors++;
         $display("FAIL timeout_err: got err,cpu_rst %b required 10", {err, cpu_rst});
      end
      checks++;
      if (n_writes - w0 !== 1) begin
         errors++;
         $display("FAIL timeout_write_count: got %0d required 1", n_writes - w0);
      end
      load_en = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid_load();
      logic [22:0] obs;
      int w0;
      load_en = 1'b1;
      repeat (4) @(negedge clk);
      send_byte(8'd5, 1'b1);
      push(8'd0, 8'hC3); send_byte(8'hC3, 1'b1);
      push(8'd1, 8'h3C); send_byte(8'h3C, 1'b1);
      repeat (CPB) @(negedge clk);
      checks++;
      if ({bus_if.writeaddr, bus_if.writeop, busy} !== {8'h02, 8'h3C, 1'b1}) begin
         errors++;
         $display("FAIL midload_state: got addr %h op %h busy %b required addr 02 op 3c busy 1",
                  bus_if.writeaddr, bus_if.writeop, busy);
      end
      #2 rst = 1'b0;
      #1;
      obs = {bus_if.write, bus_if.writeop, bus_if.writeaddr, bus_if.write_rst, cpu_rst, busy, done, err};
      checks++;
      if (obs !== {1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 3'b000}) begin
         errors++;
         $display("FAIL midload_async_reset: got %h required %h", obs, {1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 3'b000});
      end
      @(negedge clk);
      rst = 1'b1;
      w0 = n_writes;
      repeat (4) @(negedge clk);
      send_byte(8'd1, 1'b1);
      push(8'd0, 8'hAA); send_byte(8'hAA, 1'b1);
      send_byte(8'hAA, 1'b1);
      repeat (2 * CPB) @(negedge clk);
      checks++;
      if ({done, err, cpu_rst} !== 3'b101) begin
         errors++;
         $display("FAIL reload_done: got done,err,cpu_rst %b required 101", {done, err, cpu_rst});
      end
      checks++;
      if (n_writes - w0 !== 1) begin
         errors++;
         $display("FAIL reload_write_count: got %0d required 1", n_writes - w0);
      end
      load_en = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bad_sum();
      test_full_image();
      test_frame_err();
      test_glitch_timeout();
      test_reset_mid_load();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_writes: got %0d pending expected writes required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
